// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling
// constants, the 2-of-3 vote and FIFO entry sizing.
package uart_pkg;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam logic [3:0]  VOTE_TICK_0 = 4'd7;
    localparam logic [3:0]  VOTE_TICK_1 = 4'd8;
    localparam logic [3:0]  VOTE_TICK_2 = 4'd9;
    localparam logic [3:0]  LAST_TICK   = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StPush
    } rx_state_e;

    // Entry layout is {parity_err, frame_err, data}.
    function automatic int unsigned entry_width(input int unsigned data_bits);
        return data_bits + 2;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock circular-buffer FIFO with registered occupancy count.
// Push while full is accepted only when a pop takes effect in the same cycle.
module uart_rx_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [AW:0] count_q;
    logic        do_push;
    logic        do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= wr_d - rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_q[AW-1:0]];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, 2-of-3 bit vote, per-frame error flags and a
// receive FIFO with sticky overrun. Define UART_RX_PARITY_EN for even parity.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic                          rd_comp,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rd_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun
);
    import uart_pkg::*;

    localparam int unsigned EW         = entry_width(DATA_BITS);
    localparam logic [32:0] PHASE_INC  = 33'(OVERSAMPLE * BAUD_RATE);
    localparam logic [32:0] PHASE_WRAP = 33'(CLK_FREQ);
    localparam logic [3:0]  LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP  = 4'(STOP_BITS - 1);

    rx_state_e            state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic                 start_edge;
    logic [31:0]          acc_q;
    logic [32:0]          acc_sum;
    logic                 tick;
    logic [3:0]           tick_cnt_q;
    logic [1:0]           samp_q;
    logic                 vote;
    logic                 vote_tick;
    logic                 end_tick;
    logic                 bit_q;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EW-1:0]        fifo_wdata;
    logic [EW-1:0]        fifo_rdata;
    logic                 rd_en_q;
    logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
`endif

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign start_edge = (state_q == StIdle) & prev_q & ~sync2_q;

    assign acc_sum = {1'b0, acc_q} + PHASE_INC;
    assign tick    = (acc_sum >= PHASE_WRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            tick_cnt_q <= '0;
        end else if (start_edge) begin
            acc_q      <= '0;
            tick_cnt_q <= '0;
        end else begin
            acc_q <= tick ? 32'(acc_sum - PHASE_WRAP) : acc_sum[31:0];
            if (tick) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
            end
        end
    end

    assign vote_tick = tick & (tick_cnt_q == VOTE_TICK_2);
    assign end_tick  = tick & (tick_cnt_q == LAST_TICK);
    assign vote      = majority3(samp_q[0], samp_q[1], sync2_q);

    // First two vote samples are held; the third is the live line at vote_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= 2'b11;
            bit_q  <= 1'b1;
        end else begin
            if (tick && tick_cnt_q == VOTE_TICK_0) begin
                samp_q[0] <= sync2_q;
            end
            if (tick && tick_cnt_q == VOTE_TICK_1) begin
                samp_q[1] <= sync2_q;
            end
            if (vote_tick) begin
                bit_q <= vote;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        bit_cnt_d   = bit_cnt_q;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit_q;
`endif
        fifo_push   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d     = StStart;
                    bit_cnt_d   = '0;
                    frame_err_d = 1'b0;
                end
            end
            StStart: begin
                if (vote_tick && vote) begin
                    state_d = StIdle;
                end else if (end_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (end_tick) begin
                    data_d = {bit_q, data_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (end_tick) begin
                    par_bit_d = bit_q;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                // Push right after the last stop vote so the next start edge is not missed.
                if (vote_tick) begin
                    if (!vote) begin
                        frame_err_d = 1'b1;
                    end
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = StPush;
                    end
                end else if (end_tick) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            StPush: begin
                fifo_push = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= par_bit_d;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = (^data_q) ^ par_bit_q;
`else
    assign parity_err = 1'b0;
`endif

    assign fifo_wdata = {parity_err, frame_err_q, data_q};

    uart_rx_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (rd_comp),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rd_en_q <= ~fifo_empty;
            if (fifo_push && fifo_full && !rd_comp) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rd_en        = rd_en_q;
    assign overrun      = overrun_q;
    assign rd_data      = fifo_rdata[DATA_BITS-1:0];
    assign rd_frame_err = fifo_rdata[DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign rd_parity_err = fifo_rdata[EW-1];
`else
    logic unused_parity;
    assign unused_parity = fifo_rdata[EW-1];
    assign rd_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 1 tick per clock (8 data bits, 1 stop,
// depth 4); randomized frames are scored against a queue model of the FIFO.
module tb_uart_rx_fifo;
    localparam int unsigned CLK_FREQ = 1843200;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned DEPTH    = 4;
    localparam int          BIT_CYC  = 16;
    // PUSH falls 3 sync/edge cycles + vote tick 9 + 1 into the last stop bit.
    localparam int          PUSH_OFS = 13;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       rd_comp;
    logic       clr_overrun;
    logic [7:0] rd_data;
    logic       rd_frame_err;
    logic       rd_parity_err;
    logic       rd_en;
    logic [2:0] fifo_count;
    logic       overrun;

    int     checks = 0;
    int     errors = 0;
    entry_t model_q[$];
    bit     model_ovr = 1'b0;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx       (uart_rx),
        .rd_comp       (rd_comp),
        .rd_data       (rd_data),
        .rd_frame_err  (rd_frame_err),
        .rd_parity_err (rd_parity_err),
        .rd_en         (rd_en),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; optional one-cycle glitch inside data bit glitch_bit
    // and optional pop / clear pulse coinciding with the receiver's push.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic par_bit,
                              input int glitch_bit, input logic pop_at_push,
                              input logic clr_at_push);
        logic   bits[$];
        entry_t e;
        bit     dropped;
        int     goff;
        goff = $urandom_range(10, 8);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (PAR) bits.push_back(par_bit);
        bits.push_back(stop_val);
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < BIT_CYC; k++) begin
                uart_rx = (b - 1 == glitch_bit && k == goff) ? ~bits[b] : bits[b];
                rd_comp     = (b == bits.size() - 1) && (k == PUSH_OFS) && pop_at_push;
                clr_overrun = (b == bits.size() - 1) && (k == PUSH_OFS) && clr_at_push;
                step(1);
            end
        end
        rd_comp     = 1'b0;
        clr_overrun = 1'b0;
        uart_rx     = 1'b1;
        step(4);
        e.data = data;
        e.ferr = ~stop_val;
        e.perr = PAR ? ((^data) ^ par_bit) : 1'b0;
        if (pop_at_push && model_q.size() > 0) model_q.delete(0);
        dropped = (model_q.size() >= DEPTH);
        if (!dropped) model_q.push_back(e);
        if (dropped) model_ovr = 1'b1;
        else if (clr_at_push) model_ovr = 1'b0;
    endtask

    task automatic pop_head();
        rd_comp = 1'b1;
        step(1);
        rd_comp = 1'b0;
        step(1);
        if (model_q.size() > 0) model_q.delete(0);
    endtask

    task automatic test_reset();
        rst = 1'b1; uart_rx = 1'b1; rd_comp = 1'b0; clr_overrun = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        checks++;
        if ({rd_en, overrun, fifo_count} !== 5'b0) begin
            errors++;
            $display("FAIL reset got en=%0b ovr=%0b cnt=%0d want 0 0 0", rd_en, overrun, fifo_count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d = 8'hA5;
        send_frame(d, 1'b1, ^d, -1, 1'b0, 1'b0);
        checks++;
        if ({rd_en, rd_data, rd_frame_err, rd_parity_err} !== {1'b1, model_q[0]} ||
            fifo_count !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL basic got en=%0b %h f=%0b p=%0b cnt=%0d want en=1 %h f=%0b p=%0b cnt=%0d",
                     rd_en, rd_data, rd_frame_err, rd_parity_err, fifo_count,
                     model_q[0].data, model_q[0].ferr, model_q[0].perr, model_q.size());
        end
        rd_comp = 1'b1;
        step(1);
        rd_comp = 1'b0;
        model_q.delete(0);
        checks++;
        if (rd_en !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL pop_lag got en=%0b cnt=%0d want en=1 cnt=0", rd_en, fifo_count);
        end
        step(1);
        checks++;
        if (rd_en !== 1'b0) begin
            errors++;
            $display("FAIL pop_en got %0b want 0", rd_en);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] d0 = 8'h3C;
        logic [7:0] d1 = 8'h55;
        send_frame(d0, 1'b0, ^d0, -1, 1'b0, 1'b0);
        send_frame(d1, 1'b1, ^d1, -1, 1'b0, 1'b0);
        for (int n = model_q.size(); n > 0; n--) begin
            checks++;
            if ({rd_en, rd_data, rd_frame_err, rd_parity_err} !== {1'b1, model_q[0]}) begin
                errors++;
                $display("FAIL frame_err got en=%0b %h f=%0b p=%0b want en=1 %h f=%0b p=%0b",
                         rd_en, rd_data, rd_frame_err, rd_parity_err,
                         model_q[0].data, model_q[0].ferr, model_q[0].perr);
            end
            pop_head();
        end
    endtask

    task automatic test_false_start_and_vote();
        uart_rx = 1'b0;
        step(1);
        uart_rx = 1'b1;
        step(40);
        checks++;
        if (fifo_count !== 3'd0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL false_start got cnt=%0d en=%0b want 0 0", fifo_count, rd_en);
        end
        send_frame(8'hFF, 1'b1, 1'b0, int'($urandom_range(7, 0)), 1'b0, 1'b0);
        checks++;
        if ({rd_en, rd_data, rd_frame_err, rd_parity_err} !== {1'b1, model_q[0]}) begin
            errors++;
            $display("FAIL vote got en=%0b %h f=%0b p=%0b want en=1 %h f=%0b p=%0b",
                     rd_en, rd_data, rd_frame_err, rd_parity_err,
                     model_q[0].data, model_q[0].ferr, model_q[0].perr);
        end
        pop_head();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < 3; f++) begin
                logic [7:0] d;
                d = 8'($urandom);
                send_frame(d, ($urandom_range(3, 0) != 0), 1'($urandom),
                           ($urandom_range(1, 0) != 0) ? int'($urandom_range(7, 0)) : -1,
                           1'b0, 1'b0);
                checks++;
                if (fifo_count !== 3'(model_q.size())) begin
                    errors++;
                    $display("FAIL rand_count got %0d want %0d", fifo_count, model_q.size());
                end
            end
            for (int n = model_q.size(); n > 0; n--) begin
                checks++;
                if ({rd_en, rd_data, rd_frame_err, rd_parity_err} !== {1'b1, model_q[0]}) begin
                    errors++;
                    $display("FAIL rand_head got en=%0b %h f=%0b p=%0b want en=1 %h f=%0b p=%0b",
                             rd_en, rd_data, rd_frame_err, rd_parity_err,
                             model_q[0].data, model_q[0].ferr, model_q[0].perr);
                end
                pop_head();
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        // Scenario 0: plain overflow; 1: clear collides with drop; 2: pop during push.
        for (int s = 0; s < 3; s++) begin
            for (int f = 0; f < 5; f++) begin
                d = 8'($urandom);
                send_frame(d, 1'b1, ^d, -1, (s == 2 && f == 4), (s == 1 && f == 4));
            end
            checks++;
            if (fifo_count !== 3'(model_q.size()) || overrun !== model_ovr) begin
                errors++;
                $display("FAIL overrun_s%0d got cnt=%0d ovr=%0b want cnt=%0d ovr=%0b",
                         s, fifo_count, overrun, model_q.size(), model_ovr);
            end
            for (int n = model_q.size(); n > 0; n--) begin
                checks++;
                if ({rd_en, rd_data, rd_frame_err, rd_parity_err} !== {1'b1, model_q[0]}) begin
                    errors++;
                    $display("FAIL overrun_head got en=%0b %h f=%0b p=%0b want en=1 %h f=%0b p=%0b",
                             rd_en, rd_data, rd_frame_err, rd_parity_err,
                             model_q[0].data, model_q[0].ferr, model_q[0].perr);
                end
                pop_head();
            end
            clr_overrun = 1'b1;
            step(1);
            clr_overrun = 1'b0;
            model_ovr = 1'b0;
            checks++;
            if (overrun !== model_ovr) begin
                errors++;
                $display("FAIL clr_overrun got %0b want %0b", overrun, model_ovr);
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] d = 8'h07;
        send_frame(d, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        send_frame(d, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        for (int n = model_q.size(); n > 0; n--) begin
            checks++;
            if ({rd_en, rd_data, rd_frame_err, rd_parity_err} !== {1'b1, model_q[0]}) begin
                errors++;
                $display("FAIL parity got en=%0b %h f=%0b p=%0b want en=1 %h f=%0b p=%0b",
                         rd_en, rd_data, rd_frame_err, rd_parity_err,
                         model_q[0].data, model_q[0].ferr, model_q[0].perr);
            end
            pop_head();
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d = 8'h5A;
        logic [7:0] g = 8'h81;
        send_frame(8'h3E, 1'b1, ^8'h3E, -1, 1'b0, 1'b0);
        uart_rx = 1'b0;
        step(BIT_CYC);
        for (int b = 0; b < 4; b++) begin
            uart_rx = d[b];
            step(BIT_CYC);
        end
        uart_rx = d[4];
        step(5);
        rst = 1'b1;
        step(1);
        uart_rx = 1'b1;
        step(1);
        rst = 1'b0;
        model_q.delete();
        model_ovr = 1'b0;
        checks++;
        if ({rd_en, overrun, fifo_count} !== 5'b0) begin
            errors++;
            $display("FAIL midreset got en=%0b ovr=%0b cnt=%0d want 0 0 0", rd_en, overrun, fifo_count);
        end
        step(200);
        checks++;
        if (fifo_count !== 3'd0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nopush got cnt=%0d en=%0b want 0 0", fifo_count, rd_en);
        end
        send_frame(g, 1'b1, ^g, -1, 1'b0, 1'b0);
        checks++;
        if ({rd_en, rd_data, rd_frame_err, rd_parity_err} !== {1'b1, model_q[0]} ||
            fifo_count !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL after_reset got en=%0b %h f=%0b p=%0b cnt=%0d want en=1 %h f=%0b p=%0b",
                     rd_en, rd_data, rd_frame_err, rd_parity_err, fifo_count,
                     model_q[0].data, model_q[0].ferr, model_q[0].perr);
        end
        pop_head();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_false_start_and_vote();
        test_random();
        test_overrun();
        test_parity();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with receive FIFO, the next-generation serial input port for the pipelined core's memory-mapped I/O. It oversamples the line at 16x baud, majority-votes each bit, and supports configurable data width, stop bits and optional parity. Every received frame is buffered together with its per-frame error flags, and FIFO overrun is reported. It sits between the board RX pin and the core's load path, which pops entries with `rd_comp`.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in baud; 16*BAUD_RATE must be ≤ CLK_FREQ.
- `DATA_BITS`, 8, data bits per frame, 5..9, LSB first.
- `STOP_BITS`, 1, stop bits checked, 1 or 2.
- `FIFO_DEPTH`, 64, entries, power of two ≥ 2.
- `clk` in 1, system clock; the only clock.
- `rst` in 1, reset: synchronous, active-high.
- `uart_rx` in 1, asynchronous serial line, idle high.
- `rd_comp` in 1, pop the head entry; ignored when empty.
- `rd_data` out DATA_BITS, head entry data, combinational from the FIFO head.
- `rd_frame_err` out 1, head entry had a bad stop bit.
- `rd_parity_err` out 1, head entry had a parity mismatch.
- `rd_en` out 1, registered; FIFO not empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1, entries held.
- `overrun` out 1, sticky; a frame was dropped because the FIFO was full.
- `clr_overrun` in 1, clears `overrun`.

## Operation
- Input sync: `uart_rx` passes through a 2-FF synchroniser, then a third flop for edge detection. A start edge is a 1→0 transition on the synchronised signal while the receiver is in IDLE.
- Tick generator: 32-bit phase accumulator. Each cycle it adds 16*BAUD_RATE. When the sum is ≥ CLK_FREQ it subtracts CLK_FREQ and asserts a one-cycle `tick`. The accumulator is cleared on start edge detect. A 4-bit `tick_cnt` counts ticks within a bit.
- Majority vote: the synchronised line is sampled at ticks 7, 8 and 9 of each bit. The bit value is 2-of-3.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH.
  - IDLE→START on start edge.
  - START: at tick 9, a voted 1 is a false start and returns to IDLE with no push. A voted 0 goes to DATA.
  - DATA: at each bit end (tick_cnt 15), shift the voted bit in at the MSB. After DATA_BITS bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: capture the voted bit, then go to STOP.
  - STOP: check each of STOP_BITS bits. Any 0 sets frame_err. After the last stop bit's vote (tick 9), go to PUSH. The remaining half bit is not waited out, so back-to-back frames resync on the next start edge.
  - PUSH: one cycle, write {parity_err, frame_err, data} to the FIFO, then IDLE.
- Frames with errors are still stored, with their flags set.
- FIFO: circular buffer with wr/rd counters one bit wider than the pointer. count = wr − rd; full when count == FIFO_DEPTH; empty when count == 0. Pointers wrap modulo FIFO_DEPTH.
- Overrun: a PUSH while full and no pop drops the frame and sets `overrun`. A PUSH while full with `rd_comp` in the same cycle is accepted; the pop and push both take effect and count is unchanged.
- `clr_overrun` in the same cycle as a new overrun leaves `overrun` set (set wins).

## Timing
- Reset values: FSM IDLE, accumulator 0, counters 0, `rd_en` 0, `overrun` 0, `fifo_count` 0. `rd_data` and the flag outputs are undefined while empty.
- `rst` mid-frame aborts the frame with no push. The synchroniser resets to 1.
- Latency: 3-cycle synchroniser/edge delay plus frame time. The entry is visible on `rd_data` the cycle after PUSH. `rd_en` rises one cycle after that, because it is registered.
- Pop: `rd_comp` with `rd_en` high advances the head at the clock edge. The new head appears next cycle. `rd_en` follows the empty flag with one cycle of lag, so the consumer must not issue `rd_comp` on consecutive cycles without re-checking `rd_en`.
- `fifo_count` is registered and exact each cycle.

## Configuration
- `UART_RX_PARITY_EN` defined: a parity bit follows the data bits. Even parity: XOR of data and the parity bit must be 0. A mismatch sets parity_err in the entry. The PARITY state exists.
- Not defined: no parity bit, the PARITY state is removed, and `rd_parity_err` is tied to 0. The port remains present.

## Structure
- Shared package `uart_pkg`: FSM state encoding, OVERSAMPLE = 16, vote tick indices 7/8/9, and the entry-width function DATA_BITS+2.
- Sub-module `uart_rx_sync_fifo`: parametrised width and depth, push/pop, full, empty and count. It is reusable by a future TX block.
- The top level holds the synchroniser, tick generator, vote logic and FSM.

## Test plan
- Use CLK_FREQ=1_843_200 and BAUD_RATE=115200 (exactly 1 tick per clock) with 8N1. Send 0xA5 → `rd_data`=0xA5, both flags 0, `rd_en`=1, `fifo_count`=1. Pulse `rd_comp` → `rd_en`=0 after two cycles.
- Send a frame with stop bit 0 and data 0x3C → entry 0x3C with `rd_frame_err`=1. A following good 0x55 is received correctly.
- With a 1-clock-per-sample glitch low on an idle line → no push (false start). With a single-sample glitch mid-bit in 0xFF → still 0xFF (majority vote).
- With FIFO_DEPTH=4, send 5 frames without popping → `fifo_count`=4, `overrun`=1, and entries 1-4 are intact. `clr_overrun` → 0. Then fill to full and pop in the PUSH cycle → count stays 4 and the newest frame is stored.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `rd_parity_err`=1. Send 0x07 with parity bit 1 → 0.
- Assert `rst` at data bit 4 of a frame → no entry, all outputs at reset values. The next full frame 0x81 is received correctly.
